// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receive FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned C_CLKS_PER_BIT = 88;
    localparam int unsigned C_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the serial input, resets to idle (1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, single-sample at bit centre, one-cycle
//               result pulses. Define UART_RX_PARITY_EN to add a parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = C_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = C_DATA_BITS,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       C_LAST_BIT = 3'(DATA_BITS - 1);

    if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 8 || DATA_BITS < 5 ||
        DATA_BITS > 8 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx: illegal parameter value");
    end

    logic                 rx_s;
    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 cnt_end;
    logic                 mismatch;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    assign cnt_end = (cnt_q == C_CNT_END);

`ifdef UART_RX_PARITY_EN
    localparam logic C_PAR_ODD = PARITY_ODD[0];
    logic mismatch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (state_q == ST_START) begin
            mismatch_q <= 1'b0;
        end else if (state_q == ST_PARITY && cnt_end) begin
            mismatch_q <= rx_s ^ (^shift_q) ^ C_PAR_ODD;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                    end
                end

                // Half a bit in: a line that is high again was only a glitch.
                ST_START: begin
                    if (cnt_q == C_CNT_MID) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (cnt_end) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt_end) begin
                        cnt_q     <= '0;
                        rx_data_q <= shift_q;
                        perr_q    <= mismatch;
                        if (rx_s) begin
                            valid_q <= ~mismatch;
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end
                end

                // Held-low line must go idle before another start is accepted.
                ST_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard testbench for uart_rx; parity cases need UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB        = C_CLKS_PER_BIT;
    localparam int unsigned DB         = C_DATA_BITS;
    localparam int unsigned CLK_PERIOD = 10;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = DB + 3;
`else
    localparam int unsigned FRAME_BITS = DB + 2;
`endif
    // Cycles from driving the start bit to the rx_valid pulse: 3 (sync + detect) +
    // 1 (first START edge) + half bit + one bit per remaining frame bit.
    localparam int unsigned VALID_LAT  = 4 + CPB / 2 - 1 + CPB * (FRAME_BITS - 1);

    typedef struct {
        logic          valid;
        logic          ferr;
        logic          perr;
        logic [DB-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_checks;
    int   n_fail;
    int   n_pulses;
    logic any_prev;
    time  t_start;
    time  t_valid;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    // Scoreboard: every pulse pops one expected result.
    always @(negedge clk) begin
        if (rst) begin
            any_prev = 1'b0;
        end else begin
            if (rx_valid || frame_err || parity_err) begin
                n_pulses++;
                if (rx_valid) t_valid = $time;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got v/f/p=%b%b%b data=%h, required no pulse",
                             rx_valid, frame_err, parity_err, rx_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    if ({rx_valid, frame_err, parity_err} !== {e_mon.valid, e_mon.ferr, e_mon.perr} ||
                        rx_data !== e_mon.data) begin
                        n_fail++;
                        $display("FAIL scoreboard_pulse: got v/f/p=%b%b%b data=%h, required v/f/p=%b%b%b data=%h",
                                 rx_valid, frame_err, parity_err, rx_data,
                                 e_mon.valid, e_mon.ferr, e_mon.perr, e_mon.data);
                    end
                end
                n_checks++;
                if (any_prev) begin
                    n_fail++;
                    $display("FAIL pulse_width: got pulse lasting >1 cycle, required 1 cycle");
                end
            end
            any_prev = rx_valid | frame_err | parity_err;
        end
    end

    initial begin
        #(CLK_PERIOD * 60000);
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic v, input logic f, input logic p, input logic [DB-1:0] d);
        exp_t e;
        e.valid = v;
        e.ferr  = f;
        e.perr  = p;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // All bench timing is aligned to negedges, so bits follow one another with no gap.
    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        t_start = $time;
        send_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < int'(4 * CPB * FRAME_BITS)) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_valid, frame_err, parity_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v/f/p=%b%b%b busy=%b, required all 0",
                     rx_data, rx_valid, frame_err, parity_err, busy);
        end
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b data=%h, required busy=0 data=00", busy, rx_data);
        end
    endtask

    task automatic test_good_frame();
        t_valid = 0;
        push_exp(1'b1, 1'b0, 1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("good_frame");
        n_checks++;
        if ((t_valid - t_start) / CLK_PERIOD !== time'(VALID_LAT)) begin
            n_fail++;
            $display("FAIL good_frame_latency: got %0d cycles, required %0d",
                     (t_valid - t_start) / CLK_PERIOD, VALID_LAT);
        end
        n_checks++;
        if (rx_data !== 8'hA5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame_hold: got data=%h busy=%b, required data=a5 busy=0", rx_data, busy);
        end
    endtask

    task automatic test_frame_error();
        push_exp(1'b0, 1'b1, 1'b0, 8'h3C);
        send_frame(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        wait_drain("frame_error");
        n_checks++;
        if (busy !== 1'b1 || rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL break_hold: got busy=%b data=%h, required busy=1 data=3c", busy, rx_data);
        end
        rx = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_release: got busy=%b, required 0", busy);
        end
        push_exp(1'b1, 1'b0, 1'b0, 8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain("after_break");
    endtask

    task automatic test_glitch();
        int p0;
        p0 = n_pulses;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_start: got busy=%b, required 1", busy);
        end
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_pulses != p0) begin
            n_fail++;
            $display("FAIL glitch_reject: got busy=%b pulses=%0d, required busy=0 pulses=0",
                     busy, n_pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = n_pulses;
        push_exp(1'b1, 1'b0, 1'b0, 8'h00);
        push_exp(1'b1, 1'b0, 1'b0, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("back_to_back");
        n_checks++;
        if (n_pulses - p0 != 2) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d pulses, required 2", n_pulses - p0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [DB-1:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask

    task automatic test_parity();
        push_exp(1'b1, 1'b0, 1'b0, 8'h07);
        send_frame_par(8'h07, 1'b1);
        wait_drain("parity_good");
        push_exp(1'b0, 1'b0, 1'b1, 8'h07);
        send_frame_par(8'h07, 1'b0);
        wait_drain("parity_bad");
        n_checks++;
        if (parity_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_idle: got perr=%b busy=%b, required 0/0", parity_err, busy);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int p0;
        p0 = n_pulses;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got busy=%b valid=%b, required 0/0", busy, rx_valid);
        end
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB * FRAME_BITS) @(negedge clk);
        n_checks++;
        if (n_pulses != p0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abandon: got pulses=%0d busy=%b, required 0/0", n_pulses - p0, busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_pulses = 0;
        any_prev = 1'b0;
        t_start  = 0;
        t_valid  = 0;
        rst      = 1'b1;
        rx       = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_frame_error();
        test_glitch();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
